// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
// Holds the FSM state encoding, reset-cause codes and counter helpers.
package rst_seq_pkg;

  localparam int CNT_W = 8;
  // Wide enough to index up to 8 stages.
  localparam int IDX_W = 3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WD  = 2'b10;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } state_t;

  // The soft-reset counter sticks at its maximum value instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (value == CNT_MAX) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Interval timer shared by the HOLD and RELEASE phases of the sequencer.
// Counts up from zero and flags when the count equals a runtime limit.
module rst_seq_timer
  import rst_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // The limit is always an interval length minus one, so the count never wraps.
  assign done = (count == limit);

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: releases per-subsystem resets in ascending order
// after a hold time, services soft-reset requests and records the last cause.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swRstReq,
  input  logic                  wdTimeout,
  output logic [NUM_STAGES-1:0] stageRstn,
  output logic [1:0]            rstCause,
  output logic                  busy,
  output logic [CNT_W-1:0]      softRstCnt
);

  localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LIM = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);

  state_t                state;
  state_t                nextState;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      nextIdx;
  logic [NUM_STAGES-1:0] nextStageRstn;
  logic [1:0]            nextCause;
  logic [CNT_W-1:0]      nextSoftCnt;
  logic                  softReq;
  logic                  timerClr;
  logic                  timerDone;
  logic [CNT_W-1:0]      timerLimit;

  rst_seq_timer u_timer (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (timerClr),
    .limit (timerLimit),
    .done  (timerDone)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    nextState     = state;
    nextIdx       = idx;
    nextStageRstn = stageRstn;
    nextCause     = rstCause;
    nextSoftCnt   = softRstCnt;
    timerClr      = 1'b0;
    timerLimit    = (state == HOLD) ? HOLD_LIM : STAGE_LIM;

    // Software requests only count once the system is running; the watchdog
    // restarts the sequence from any state, every cycle it is asserted.
    softReq = wdTimeout | (swRstReq & (state == RUN));

    if (softReq) begin
      nextState     = HOLD;
      nextIdx       = '0;
      nextStageRstn = '0;
      nextCause     = wdTimeout ? CAUSE_WD : CAUSE_SW;
      nextSoftCnt   = satInc(softRstCnt);
      timerClr      = 1'b1;
    end else begin
      case (state)
        HOLD: begin
          if (timerDone) begin
            nextStageRstn[0] = 1'b1;
            nextIdx          = IDX_W'(1);
            timerClr         = 1'b1;
            nextState        = (NUM_STAGES == 1) ? RUN : RELEASE;
          end
        end
        RELEASE: begin
          if (timerDone) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
              if (idx == IDX_W'(k)) nextStageRstn[k] = 1'b1;
            end
            nextIdx  = idx + IDX_W'(1);
            timerClr = 1'b1;
            if (idx == LAST_IDX) nextState = RUN;
          end
        end
        RUN: begin
          timerClr = 1'b1;
        end
        default: begin
          nextState = HOLD;
          timerClr  = 1'b1;
        end
      endcase
    end
  end

  // NOTE: rstn is sampled synchronously; it overrides every request and
  // returns all registers, including the soft-reset count, to POR values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= HOLD;
      idx        <= '0;
      stageRstn  <= '0;
      rstCause   <= CAUSE_POR;
      busy       <= 1'b1;
      softRstCnt <= '0;
    end else begin
      state      <= nextState;
      idx        <= nextIdx;
      stageRstn  <= nextStageRstn;
      rstCause   <= nextCause;
      busy       <= (nextState != RUN);
      softRstCnt <= nextSoftCnt;
    end
  end

endmodule
